// File: rtl/ltssm_pkg.sv
// Shared LTSSM encodings: substates, sequencer FSM states, Gen constants.
// Used by the substate sequencer and the Rx/Tx LTSSM halves.
package ltssm_pkg;

  localparam logic [3:0] DETECT_QUIET         = 4'd0;
  localparam logic [3:0] DETECT_ACTIVE        = 4'd1;
  localparam logic [3:0] POLLING_ACTIVE       = 4'd2;
  localparam logic [3:0] POLLING_CONFIG       = 4'd3;
  localparam logic [3:0] CFG_LINK_WIDTH_START = 4'd4;
  localparam logic [3:0] CFG_LINK_WIDTH_ACCEPT = 4'd5;
  localparam logic [3:0] CFG_LANE_NUM_WAIT    = 4'd6;
  localparam logic [3:0] CFG_LANE_NUM_ACCEPT  = 4'd7;
  localparam logic [3:0] CFG_COMPLETE         = 4'd8;
  localparam logic [3:0] CFG_IDLE             = 4'd9;
  localparam logic [3:0] L0                   = 4'd10;
  localparam logic [3:0] REC_RCVR_LOCK        = 4'd11;
  localparam logic [3:0] REC_SPEED            = 4'd12;
  localparam logic [3:0] REC_RCVR_CFG         = 4'd13;
  localparam logic [3:0] REC_IDLE             = 4'd14;
  localparam logic [3:0] RESERVED_SUBSTATE    = 4'd15;

  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DECIDE
  } seqState_t;

  // Gen 0 is not a real rate, so it means Gen1.
  function automatic logic [2:0] clampGen(
    input logic [2:0] target,
    input logic [2:0] maxGen
  );
    logic [2:0] g;
    g = (target == 3'd0) ? GEN1 : target;
    if (g > maxGen) g = maxGen;
    return g;
  endfunction

endpackage

// File: rtl/ltssm_watchdog.sv
// Hang watchdog: counts while enabled, pulses expire on the last count.
// Clear reloads to zero; shared by the sequencer and the Tx half.
module ltssm_watchdog #(
  parameter logic [23:0] CYCLES = 24'd12_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [23:0] count;

  assign expire = enable && (count == CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (expire) count <= '0;
      else        count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/ltssm_substate_sequencer.sv
// Owns the shared LTSSM substate; arbitrates Rx/Tx exit requests and Gen.
// Define LTSSM_RECOVERY_COUNT_EN to add the L0->Recovery counter output.
module ltssm_substate_sequencer
  import ltssm_pkg::*;
#(
  parameter logic [23:0] WATCHDOG_CYCLES = 24'd12_000_000,
  parameter int unsigned MAX_GEN         = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rxFinish,
  input  logic [3:0] rxExitTo,
  input  logic       txFinish,
  input  logic [3:0] txExitTo,
  input  logic       directed_speed_change,
  input  logic [2:0] trainToGen,
  output logic [3:0] substate,
  output logic [2:0] Gen,
  output logic       startPulse,
  output logic       linkUp,
  output logic       mismatchError,
  output logic       watchdogError
`ifdef LTSSM_RECOVERY_COUNT_EN
  ,
  output logic [7:0] recoveryCount
`endif
);

  localparam logic [2:0] MAX_GEN_L = 3'(MAX_GEN);

  seqState_t  state, stateNext;
  logic [3:0] substateNext;
  logic [2:0] genNext;
  logic       mismatchNext, watchdogNext;
  logic       rxDone, txDone;
  logic [3:0] rxExit, txExit;
  logic       bothDone, wdExpire;
  logic [3:0] agreedExit;

  assign startPulse = (state == SEQ_ISSUE);
  assign bothDone   = (rxDone | rxFinish) & (txDone | txFinish);
  assign agreedExit = (rxExit == RESERVED_SUBSTATE) ? DETECT_QUIET : rxExit;

  ltssm_watchdog #(
    .CYCLES(WATCHDOG_CYCLES)
  ) uWatchdog (
    .clk   (clk),
    .reset (reset),
    .clear (state == SEQ_ISSUE),
    .enable(state == SEQ_WAIT),
    .expire(wdExpire)
  );

  always_comb begin
    stateNext    = state;
    substateNext = substate;
    genNext      = Gen;
    mismatchNext = 1'b0;
    watchdogNext = 1'b0;
    if (!enable) begin
      stateNext    = SEQ_IDLE;
      substateNext = DETECT_QUIET;
      genNext      = GEN1;
    end else begin
      unique case (state)
        SEQ_IDLE:  stateNext = SEQ_ISSUE;
        SEQ_ISSUE: stateNext = SEQ_WAIT;
        SEQ_WAIT: begin
          if (bothDone) begin
            stateNext = SEQ_DECIDE;
          end else if (wdExpire) begin
            stateNext    = SEQ_ISSUE;
            substateNext = DETECT_QUIET;
            genNext      = GEN1;
            watchdogNext = 1'b1;
          end
        end
        SEQ_DECIDE: begin
          stateNext = SEQ_ISSUE;
          if (rxExit != txExit) begin
            mismatchNext = 1'b1;
            substateNext = DETECT_QUIET;
          end else begin
            substateNext = agreedExit;
          end
          if (substateNext == DETECT_QUIET)
            genNext = GEN1;
          else if (substate == REC_RCVR_CFG &&
                   substateNext == REC_SPEED &&
                   directed_speed_change)
            genNext = clampGen(trainToGen, MAX_GEN_L);
        end
        default: stateNext = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SEQ_IDLE;
      substate      <= DETECT_QUIET;
      Gen           <= GEN1;
      linkUp        <= 1'b0;
      mismatchError <= 1'b0;
      watchdogError <= 1'b0;
      rxDone        <= 1'b0;
      txDone        <= 1'b0;
      rxExit        <= '0;
      txExit        <= '0;
    end else begin
      state         <= stateNext;
      substate      <= substateNext;
      Gen           <= genNext;
      linkUp        <= (substateNext == L0);
      mismatchError <= mismatchNext;
      watchdogError <= watchdogNext;
      if (state == SEQ_ISSUE) begin
        rxDone <= 1'b0;
        txDone <= 1'b0;
      end else if (state == SEQ_WAIT) begin
        // First report wins; repeats are ignored.
        if (rxFinish && !rxDone) begin
          rxDone <= 1'b1;
          rxExit <= rxExitTo;
        end
        if (txFinish && !txDone) begin
          txDone <= 1'b1;
          txExit <= txExitTo;
        end
      end
    end
  end

`ifdef LTSSM_RECOVERY_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || substateNext == DETECT_QUIET) begin
      recoveryCount <= '0;
    end else if (enable && state == SEQ_DECIDE &&
                 substate == L0 &&
                 substateNext == REC_RCVR_LOCK &&
                 recoveryCount != 8'hFF) begin
      recoveryCount <= recoveryCount + 8'd1;
    end
  end
`endif

endmodule
